// File: rtl/mem_pkg.sv
// Shared types and constants for the data-RAM access path.
// Request fields are carried at MEM_WIDTH; narrower arbiters zero-extend into them.
package mem_pkg;

    localparam int unsigned MEM_WIDTH = 32;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic [1:0]           mode;
        logic [MEM_WIDTH-1:0] addr;
        logic [MEM_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin choice: a lone requester wins, a tie goes to the port
// that did not hold the last grant.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       owner,
    output logic       grant_idx,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~owner;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU (port 0) and debug/DMA (port 1) accesses onto the single data RAM
// through an IDLE -> ACCESS -> RESP sequence with registered request and response.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [1:0]       m0_mode,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [1:0]       m1_mode,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             ram_we,
    output logic [1:0]       ram_mode,
    output logic [WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             busy,
    output logic             owner
);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    mem_req_t         req_q, req_d;
    logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
    logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
    logic             grant_idx;
    logic             grant_valid;

    rr_pick2 u_pick (
        .req         ({m1_req, m0_req}),
        .owner       (owner_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        req_d      = req_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_idx) begin
                        req_d.we    = m1_we;
                        req_d.mode  = m1_mode;
                        req_d.addr  = MEM_WIDTH'(m1_addr);
                        req_d.wdata = MEM_WIDTH'(m1_wdata);
                    end else begin
                        req_d.we    = m0_we;
                        req_d.mode  = m0_mode;
                        req_d.addr  = MEM_WIDTH'(m0_addr);
                        req_d.wdata = MEM_WIDTH'(m0_wdata);
                    end
                    owner_d = grant_idx;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Only the winner's response register is written; the loser's holds.
                if (owner_q) m1_rdata_d = ram_dout;
                else         m0_rdata_d = ram_dout;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            req_q      <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            req_q      <= req_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Strobe and acks decode straight from state so an async reset kills them at once.
    assign ram_we   = (state_q == ACCESS) && req_q.we;
    assign ram_mode = req_q.mode;
    assign ram_addr = WIDTH'(req_q.addr);
    assign ram_din  = WIDTH'(req_q.wdata);
    assign m0_ack   = (state_q == RESP) && !owner_q;
    assign m1_ack   = (state_q == RESP) && owner_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares the single data RAM between the CPU load/store path (port 0) and a second requester (port 1: debug/DMA loader). It sits between the requesters and the RAM's `we/mode/addr/din/dout` pins and serialises accesses through a three-state FSM. Each access gets registered request fields, an exactly one-cycle RAM write strobe, and a registered read response with a one-cycle `ack`. The CPU uses `m0_req & ~m0_ack` as its stall, gating the PC register enable.

## Interface
Parameters:
- `WIDTH`, 32, data/address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request; held high until `ack`.
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load.
- `m0_mode`, `m1_mode`  in  2  access size: 00 byte, 01 half, 10 word; 11 is passed through unchanged.
- `m0_addr`, `m1_addr`  in  WIDTH  byte address.
- `m0_wdata`, `m1_wdata`  in  WIDTH  store data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  WIDTH  load data; valid while the matching `ack` is high; holds last value otherwise.
- `ram_we`  out  1  RAM write strobe.
- `ram_mode`  out  2  to RAM `mode`.
- `ram_addr`  out  WIDTH  to RAM `addr`.
- `ram_din`  out  WIDTH  to RAM `din`.
- `ram_dout`  in  WIDTH  combinational RAM read data.
- `busy`  out  1  high in ACCESS and RESP.
- `owner`  out  1  port index of the current or last grant.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:**
  - If any `req` is high, pick a winner.
  - Only one port requesting: that port wins.
  - Both ports requesting: the port ≠ `owner` wins (round-robin).
  - Latch the winner's `we/mode/addr/wdata` into the request registers, set `owner`, go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS** (exactly one cycle):
  - `ram_*` are driven from the request registers.
  - `ram_we` = latched `we`.
  - `ram_dout` is captured into the winner's `rdata` register at the closing edge.
  - Go to RESP.
- **RESP** (exactly one cycle):
  - Winner's `ack` = 1.
  - Go to IDLE unconditionally.
- Requester rule: after seeing `ack`, the requester drops `req` at that same edge unless it issues a new request. A `req` high in the IDLE cycle after `ack` is a new access.
- Outside ACCESS: `ram_we` = 0; `ram_addr/mode/din` hold the request registers.
- `ack` is never asserted on both ports at once. Loser data registers are untouched.
- Changes to request fields after the IDLE sampling edge are ignored until the next grant.
- No alignment or range checking; `mode` and `addr` pass through verbatim.

## Timing
- Latency: `req` sampled high in IDLE at edge 0 → ACCESS in cycle 1 → `ack` in cycle 2. Throughput is one access per 3 cycles.
- Starvation bound: a pending request is granted within 6 cycles of assertion.
- Reset values: state IDLE, `owner` = 1 (so port 0 wins the first tie), both `ack` = 0, both `rdata` = 0, request registers = 0, `ram_we` = 0, `busy` = 0.
- Reset mid-operation: asynchronous abort from any state.
  - `ram_we` drops immediately, so the store in ACCESS is not performed if reset precedes the edge.
  - No `ack` is issued; requesters re-issue after reset.
- Simultaneous requests arriving during ACCESS/RESP wait in IDLE and are resolved by `owner` there.

## Structure
- Shared package `mem_pkg`:
  - state enum `arb_state_t` {IDLE, ACCESS, RESP};
  - mode constants `MODE_BYTE` = 2'b00, `MODE_HALF` = 2'b01, `MODE_WORD` = 2'b10;
  - packed struct `mem_req_t` {we, mode, addr, wdata}.
- One sub-module, `rr_pick2`: combinational two-way round-robin choice from (`req[1:0]`, `owner`) → `grant_idx`, `grant_valid`.
- Top level holds the FSM, request registers and response registers.

## Test plan
- **Single load, port 0:** RAM word 0x10 = 0xDEADBEEF; `m0_req`, `we` = 0, `mode` = 10, `addr` = 0x10 at cycle 0 → `ram_addr` = 0x10 in cycle 1; `m0_ack` = 1 with `m0_rdata` = 0xDEADBEEF in cycle 2; `ram_we` = 0 throughout.
- **Store, port 1:** `m1_req`, `we` = 1, `mode` = 00, `addr` = 0x21, `wdata` = 0xA5 → `ram_we` high only in cycle 1 with `addr` 0x21, `din` 0xA5, `mode` 00; `m1_ack` in cycle 2; a later port-0 byte load of 0x21 returns 0xA5.
- **Tie after reset:** both ports request at cycle 0 and hold → port 0 acked at cycle 2, port 1 acked at cycle 5, `owner` = 1 afterwards.
- **Fairness:** both ports keep re-requesting for 12 cycles → acks alternate 0,1,0,1; no port waits more than 6 cycles.
- **Reset in ACCESS:** port 1 store to 0x40 = 0x1234; `rst` low mid cycle 1 → `ram_we` drops immediately, RAM word 0x40 unchanged, no `ack`, state IDLE, all outputs at reset values.
- **Field change after grant:** port 0 changes `addr` 0x10 → 0x20 in cycle 1 → access still uses 0x10.
